// File: rtl/y_sig_compactor.sv
// y_sig_compactor
// Folds a wide DUT output vector into a SIG_W-bit MISR signature over a
// window of WINDOW accepted samples, then presents the signature through a
// valid/ack handshake.
// Optional feature: define Y_SIG_COMPACTOR_CMP_EN to add the expect_sig input
// and the registered mismatch flag.
module y_sig_compactor #(
   parameter int               IN_W   = 421,
   parameter int               SIG_W  = 32,
   parameter logic [SIG_W-1:0] POLY   = SIG_W'(32'h04C11DB7),
   parameter logic [SIG_W-1:0] SEED   = '0,
   parameter int               WINDOW = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   y_in,
   input  logic              sample_en,
   input  logic              start,
   output logic              busy,
   output logic              sig_valid,
   output logic [SIG_W-1:0]  sig,
   input  logic              sig_ack,
   output logic [15:0]       samples
`ifdef Y_SIG_COMPACTOR_CMP_EN
   ,
   input  logic [SIG_W-1:0]  expect_sig,
   output logic              mismatch
`endif
);

   // Number of SIG_W chunks after zero-padding y_in at the MSB end.
   localparam int          N_CHUNK  = (IN_W + SIG_W - 1) / SIG_W;
   localparam int          PAD_W    = N_CHUNK * SIG_W;
   localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [SIG_W-1:0]   r_sig;
   logic [15:0]        r_samples;
   logic [PAD_W-1:0]   w_y_pad;
   logic [SIG_W-1:0]   w_fold;
   logic [SIG_W-1:0]   w_sig_next;
   logic               w_accept;
   logic               w_last;
   logic               w_load;

   // Zero-pad y_in and XOR all chunks together into one SIG_W word.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so the running XOR sees
      // each previous iteration; every output gets a default first so no
      // latch can be inferred.
      w_y_pad             = '0;
      w_y_pad[IN_W-1:0]   = y_in;
      w_fold              = '0;
      for (int c = 0; c < N_CHUNK; c++) begin
         w_fold = w_fold ^ w_y_pad[c*SIG_W +: SIG_W];
      end
   end

   // One MISR step: shift left, apply feedback on MSB, inject the fold.
   assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? POLY : '0)
                     ^ w_fold;

   assign w_load   = (r_state == S_IDLE) && start;
   assign w_accept = (r_state == S_RUN) && sample_en;
   assign w_last   = w_accept && (r_samples == WIN_LAST);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so all registers
      // update together from pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic: start only counts in IDLE, ack only in DONE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)   w_state_next = S_RUN;
         S_RUN:   if (w_last)  w_state_next = S_DONE;
         S_DONE:  if (sig_ack) w_state_next = S_IDLE;
         default:              w_state_next = S_IDLE;
      endcase
   end

   // Signature and sample counter: load on start, step on accepted samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig     <= '0;
         r_samples <= '0;
      end else if (w_load) begin
         r_sig     <= SEED;
         r_samples <= '0;
      end else if (w_accept) begin
         r_sig     <= w_sig_next;
         r_samples <= r_samples + 16'd1;
      end
   end

`ifdef Y_SIG_COMPACTOR_CMP_EN
   logic r_mismatch;

   // Capture the compare result on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst)         r_mismatch <= 1'b0;
      else if (w_load) r_mismatch <= 1'b0;
      else if (w_last) r_mismatch <= (w_sig_next != expect_sig);
   end

   assign mismatch = r_mismatch;
`endif

   assign busy      = (r_state == S_RUN);
   assign sig_valid = (r_state == S_DONE);
   assign sig       = r_sig;
   assign samples   = r_samples;

endmodule

// File: tb/tb_y_sig_compactor.sv
// Testbench for y_sig_compactor: randomized windows against a behavioural
// model, with a scoreboard monitor checking each presented signature.
module tb_y_sig_compactor;

   localparam int          IN_W  = 421;
   localparam int          WIN   = 4;
   localparam logic [31:0] POLY  = 32'h04C11DB7;
   localparam logic [31:0] SEED0 = 32'h0;
   localparam logic [31:0] SEED1 = 32'hA5A50F0F;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            sample_en = 1'b0;
   logic            start = 1'b0;
   logic            sig_ack = 1'b0;
   logic            start1 = 1'b0;
   logic            sig_ack1 = 1'b0;
   logic [IN_W-1:0] y_in = '0;
   logic [31:0]     expect_sig = '0;

   logic            busy, sig_valid, busy1, sig_valid1;
   logic [31:0]     sig, sig1;
   logic [15:0]     samples, samples1;
`ifdef Y_SIG_COMPACTOR_CMP_EN
   logic            mismatch, mismatch1;
`endif

   always #5 clk = ~clk;

   y_sig_compactor #(.IN_W(IN_W), .SIG_W(32), .POLY(POLY), .SEED(SEED0), .WINDOW(WIN)) dut (
      .clk(clk), .rst(rst), .y_in(y_in), .sample_en(sample_en), .start(start),
      .busy(busy), .sig_valid(sig_valid), .sig(sig), .sig_ack(sig_ack), .samples(samples)
`ifdef Y_SIG_COMPACTOR_CMP_EN
      , .expect_sig(expect_sig), .mismatch(mismatch)
`endif
   );

   y_sig_compactor #(.IN_W(IN_W), .SIG_W(32), .POLY(POLY), .SEED(SEED1), .WINDOW(1)) dut_w1 (
      .clk(clk), .rst(rst), .y_in(y_in), .sample_en(sample_en), .start(start1),
      .busy(busy1), .sig_valid(sig_valid1), .sig(sig1), .sig_ack(sig_ack1), .samples(samples1)
`ifdef Y_SIG_COMPACTOR_CMP_EN
      , .expect_sig(expect_sig), .mismatch(mismatch1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Fold: bit i of y lands in signature bit (i mod 32).
   function automatic logic [31:0] m_fold(input logic [IN_W-1:0] y);
      logic [31:0] f = '0;
      for (int i = 0; i < IN_W; i++) if (y[i]) f[i % 32] = ~f[i % 32];
      return f;
   endfunction

   // Multiply by x modulo the polynomial, then add the folded sample.
   function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] f);
      logic [31:0] r = s << 1;
      if (s[31]) r = r ^ POLY;
      return r ^ f;
   endfunction

   function automatic logic [IN_W-1:0] rand_y();
      logic [IN_W-1:0] y;
      logic [31:0]     w = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (i % 32 == 0) w = $urandom;
         y[i] = w[i % 32];
      end
      return y;
   endfunction

   typedef struct {
      logic [31:0] sig;
      logic [15:0] samples;
      logic        mism;
   } exp_t;

   exp_t        sb_q[$];
   int          m_mode = 0;   // 0 idle, 1 collecting, 2 holding result
   logic [31:0] m_sig = '0;
   logic [15:0] m_samples = '0;
   logic        m_mism = 1'b0;

   // Drive one cycle, advance the model, then compare visible state.
   task automatic cyc(input logic en, input logic [IN_W-1:0] y, input logic st,
                      input logic ack, input logic r);
      sample_en = en; y_in = y; start = st; sig_ack = ack; rst = r;
      if (r) begin
         m_mode = 0; m_sig = '0; m_samples = '0; m_mism = 1'b0;
      end else begin
         case (m_mode)
            0: if (st) begin
                  m_mode = 1; m_sig = SEED0; m_samples = '0; m_mism = 1'b0;
               end
            1: if (en) begin
                  m_sig = m_step(m_sig, m_fold(y));
                  m_samples = m_samples + 16'd1;
                  if (m_samples == 16'(WIN)) begin
                     m_mode = 2;
                     m_mism = (m_sig != expect_sig);
                     sb_q.push_back('{sig: m_sig, samples: m_samples, mism: m_mism});
                  end
               end
            default: if (ack) m_mode = 0;
         endcase
      end
      @(posedge clk);
      #1;
      sample_en = 1'b0; start = 1'b0; sig_ack = 1'b0; rst = 1'b0;
      check("busy", busy, m_mode == 1);
      check("sig_valid", sig_valid, m_mode == 2);
      check("sig", sig, m_sig);
      check("samples", samples, m_samples);
   endtask

   // ---------------- scoreboard monitor ----------------
   logic mon_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sig_valid === 1'b1 && mon_prev !== 1'b1) begin
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("sb_sig", sig, e.sig);
               check("sb_samples", samples, e.samples);
`ifdef Y_SIG_COMPACTOR_CMP_EN
               check("sb_mismatch", mismatch, e.mism);
`endif
            end
         end
         mon_prev = sig_valid;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [IN_W-1:0] z, y_one, y_f0, y_b31, yr;
      logic [IN_W-1:0] ys[4];
      z = '0; y_one = '0; y_one[0] = 1'b1;
      y_f0 = '0; y_f0[0] = 1'b1; y_f0[32] = 1'b1;
      y_b31 = '0; y_b31[31] = 1'b1;

      // Reset state
      cyc(0, z, 0, 0, 1);
      cyc(0, z, 0, 0, 1);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", sig_valid, 1'b0);
      check("rst_sig", sig, 32'h0);
      check("rst_samples", samples, 16'h0);

      // Zero input window
      cyc(0, z, 1, 0, 0);
      check("start_busy", busy, 1'b1);
      repeat (3) cyc(1, z, 0, 0, 0);
      check("zero_not_done", sig_valid, 1'b0);
      cyc(1, z, 0, 0, 0);
      check("zero_sig", sig, 32'h0);
      check("zero_samples", samples, 16'd4);
      check("zero_valid", sig_valid, 1'b1);
      cyc(0, z, 0, 1, 0);

      // Shift check, expected signature matching then not matching
      for (int pass = 0; pass < 2; pass++) begin
         expect_sig = (pass == 0) ? 32'd15 : 32'd14;
         cyc(0, z, 1, 0, 0);
         cyc(1, y_one, 0, 0, 0);
         check("shift1", sig, 32'd1);
         cyc(1, y_one, 0, 0, 0);
         check("shift2", sig, 32'd3);
         cyc(1, y_one, 0, 0, 0);
         cyc(1, y_one, 0, 0, 0);
         check("shift4", sig, 32'd15);
         cyc(0, z, 0, 1, 0);
      end
      expect_sig = '0;

      // Fold cancellation, feedback, start ignored in RUN and DONE
      cyc(0, z, 1, 0, 0);
      cyc(1, y_f0, 0, 0, 0);
      check("fold_cancel", sig, 32'h0);
      cyc(1, y_b31, 1, 0, 0);
      check("msb_set", sig, 32'h80000000);
      cyc(1, z, 0, 0, 0);
      check("feedback", sig, 32'h04C11DB7);
      cyc(1, rand_y(), 0, 0, 0);
      cyc(0, z, 1, 0, 0);
      cyc(0, z, 1, 1, 0);
      cyc(0, z, 0, 0, 0);
      check("start_ack_dropped", busy, 1'b0);
      cyc(0, z, 0, 1, 0);   // ack in IDLE: no effect

      // Gapped sampling: 1,0,1,0,1,0,1
      cyc(0, z, 1, 0, 0);
      for (int k = 0; k < 7; k++) cyc(k % 2 == 0, rand_y(), 0, 0, 0);
      check("gap_done", sig_valid, 1'b1);
      cyc(0, z, 0, 1, 0);

      // Reset mid-window, then a clean run with the same data
      for (int k = 0; k < 4; k++) ys[k] = rand_y();
      cyc(0, z, 1, 0, 0);
      for (int k = 0; k < 3; k++) cyc(1, ys[k], 0, 0, 0);
      cyc(0, z, 0, 0, 1);
      check("midrst_sig", sig, 32'h0);
      cyc(0, z, 1, 0, 0);
      for (int k = 0; k < 4; k++) cyc(1, ys[k], 0, 0, 0);
      cyc(0, z, 0, 1, 0);

      // Randomized windows with start/ack noise
      for (int w = 0; w < 30; w++) begin
         expect_sig = ($urandom % 2 == 0) ? m_sig : $urandom;
         cyc(0, z, 1, 0, 0);
         for (int k = 0; k < 200 && m_mode == 1; k++)
            cyc($urandom % 3 != 0, rand_y(), $urandom % 8 == 0, $urandom % 8 == 0, 0);
         check("window_finished", m_mode == 2, 1'b1);
         repeat ($urandom_range(0, 3)) cyc(0, rand_y(), $urandom % 2 == 0, 0, 0);
         cyc(0, z, 0, 1, 0);
      end

      // WINDOW=1 instance: one sample goes straight to DONE
      start1 = 1'b1;
      cyc(0, z, 0, 0, 0);
      start1 = 1'b0;
      check("w1_busy", busy1, 1'b1);
      check("w1_seed", sig1, SEED1);
      yr = rand_y();
      expect_sig = m_step(SEED1, m_fold(yr)) ^ 32'h1;
      cyc(1, yr, 0, 0, 0);
      check("w1_valid", sig_valid1, 1'b1);
      check("w1_busy_low", busy1, 1'b0);
      check("w1_sig", sig1, m_step(SEED1, m_fold(yr)));
      check("w1_samples", samples1, 16'd1);
`ifdef Y_SIG_COMPACTOR_CMP_EN
      check("w1_mismatch", mismatch1, 1'b1);
`endif
      sig_ack1 = 1'b1;
      cyc(0, z, 0, 0, 0);
      sig_ack1 = 1'b0;
      check("w1_ack", sig_valid1, 1'b0);
      check("w1_sig_hold", sig1, m_step(SEED1, m_fold(yr)));

      repeat (3) cyc(0, z, 0, 0, 0);
      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
